// File: rtl/axis_width_down_conv.sv
// rtl/axis_width_down_conv.sv - AXI4-Stream width down-converter, one wide word out as IN_W/OUT_W narrow slices, LSB first
// Optional macro TLAST_TRUNC_EN: a slice flagged tlast ends its word early and the higher slices are dropped.
module axis_width_down_conv #(
  parameter int IN_W  = 1536,
  parameter int OUT_W = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_W-1:0]           s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [IN_W/OUT_W-1:0]     s_axis_tlast,
  output logic [OUT_W-1:0]          m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IN_W-1:0]  buf_q, buf_d;
  logic [RATIO-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             full_q, full_d;

  logic [OUT_W-1:0] slices [RATIO];
  logic             final_slice;
  logic             in_xfer;
  logic             out_xfer;

  // Constant-index slicing keeps the output mux a plain array select.
  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slices[g] = buf_q[g*OUT_W +: OUT_W];
  end

  assign m_axis_tdata  = slices[idx_q];
  assign m_axis_tlast  = last_q[idx_q] & full_q;
  assign m_axis_tvalid = full_q;

`ifdef TLAST_TRUNC_EN
  assign final_slice = full_q & ((idx_q == LAST_IDX) | last_q[idx_q]);
`else
  assign final_slice = full_q & (idx_q == LAST_IDX);
`endif

  // Ready depends only on buffer state and downstream ready, never on s_axis_tvalid.
  assign s_axis_tready = ~full_q | (final_slice & m_axis_tready);

  assign in_xfer  = s_axis_tvalid & s_axis_tready;
  assign out_xfer = full_q & m_axis_tready;

  always_comb begin
    buf_d  = buf_q;
    last_d = last_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (in_xfer) begin
      buf_d  = s_axis_tdata;
      last_d = s_axis_tlast;
      idx_d  = '0;
      full_d = 1'b1;
    end else if (out_xfer) begin
      if (final_slice) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q  <= '0;
      last_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      last_q <= last_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule
